// File: rtl/sg_wrseq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sg_wrseq_pkg
// Description : Shared types and constants for the signal-generator register
//               write sequencer: bus widths, FSM state encoding, generator
//               register map and the queued command record.
// Revision    : 1.0 - initial release
// ============================================================================
package sg_wrseq_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 5;

  // Sequencer states; explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    GAP    = 2'd3
  } state_t;

  // Signal-generator register map
  localparam logic [ADDR_W-1:0] c_REG_CTRL      = 3'd0;
  localparam logic [ADDR_W-1:0] c_REG_WAVEFORM  = 3'd1;
  localparam logic [ADDR_W-1:0] c_REG_FREQ_LO   = 3'd2;
  localparam logic [ADDR_W-1:0] c_REG_FREQ_HI   = 3'd3;
  localparam logic [ADDR_W-1:0] c_REG_AMPLITUDE = 3'd4;
  localparam logic [ADDR_W-1:0] c_REG_OFFSET    = 3'd5;
  localparam logic [ADDR_W-1:0] c_REG_PHASE     = 3'd6;
  localparam logic [ADDR_W-1:0] c_REG_DUTY      = 3'd7;

  // One queued register write
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  // Largest of three cycle counts, used to size the shared down-counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sg_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sg_cmd_fifo
// Description : Synchronous show-ahead FIFO of cmd_t. The head entry is always
//               visible on dout; a push while full is dropped even if a pop
//               happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sg_cmd_fifo
  import sg_wrseq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sg_reg_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sg_reg_write_sequencer
// Description : Queues register-write commands and replays each one to the
//               signal generator as setup / stretched strobe / gap, so the
//               generator's slow scaled clock samples the strobe reliably.
//               Optional feature macro: SGWR_SHADOW_EN (8x5 shadow copy of
//               every register written, readable via shadow_addr/shadow_data).
// Revision    : 1.0 - initial release
// ============================================================================
module sg_reg_write_sequencer
  import sg_wrseq_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 128,
  parameter int GAP_CYCLES    = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              write_strobe,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              busy
`ifdef SGWR_SHADOW_EN
  ,
  input  logic [ADDR_W-1:0] shadow_addr,
  output logic [DATA_W-1:0] shadow_data
`endif
);

  localparam int c_MAX_CYC = max3(SETUP_CYCLES, STROBE_CYCLES, GAP_CYCLES);
  localparam int CNT_W     = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] c_SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_GAP_LD    = CNT_W'(GAP_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  cmd_t             w_head;
  cmd_t             w_cmd_in;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_cnt_done;

  assign cmd_ready  = !w_full;
  assign w_pop      = (r_state == IDLE) && !w_empty;
  assign w_cnt_done = (r_cnt == '0);
  assign w_cmd_in   = '{addr: cmd_addr, data: cmd_data};

  sg_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .pop   (w_pop),
    .din   (w_cmd_in),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Sequencer FSM: pops a command in IDLE, then walks setup/strobe/gap using
  // one shared down-counter loaded with N-1 on each state entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      write_strobe <= 1'b0;
      address      <= '0;
      data         <= '0;
      busy         <= 1'b0;
    end else begin
      busy <= (r_state != IDLE) || !w_empty;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            address <= w_head.addr;
            data    <= w_head.data;
            r_cnt   <= c_SETUP_LD;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (w_cnt_done) begin
            write_strobe <= 1'b1;
            r_cnt        <= c_STROBE_LD;
            r_state      <= STROBE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        STROBE: begin
          if (w_cnt_done) begin
            write_strobe <= 1'b0;
            r_cnt        <= c_GAP_LD;
            r_state      <= GAP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (w_cnt_done) r_state <= IDLE;
          else            r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SGWR_SHADOW_EN
  logic [DATA_W-1:0] r_shadow [8];

  // Shadow copy captures the write as the strobe falls (STROBE -> GAP)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_shadow[i] <= '0;
    end else if ((r_state == STROBE) && w_cnt_done) begin
      r_shadow[address] <= data;
    end
  end

  assign shadow_data = r_shadow[shadow_addr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_sg_reg_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sg_reg_write_sequencer
// Description : Directed self-checking bench for sg_reg_write_sequencer with
//               SETUP=2, STROBE=4, GAP=3, DEPTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sg_reg_write_sequencer;

  localparam int SETUP  = 2;
  localparam int STROBE = 4;
  localparam int GAP    = 3;
  localparam int DEPTH  = 4;
  localparam int PERIOD = STROBE + GAP + 1 + SETUP;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_addr;
  logic [4:0] cmd_data;
  logic       write_strobe;
  logic [2:0] address;
  logic [4:0] data;
  logic       busy;
`ifdef SGWR_SHADOW_EN
  logic [2:0] shadow_addr;
  logic [4:0] shadow_data;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sg_reg_write_sequencer #(
    .FIFO_DEPTH    (DEPTH),
    .SETUP_CYCLES  (SETUP),
    .STROBE_CYCLES (STROBE),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .write_strobe (write_strobe),
    .address      (address),
    .data         (data),
    .busy         (busy)
`ifdef SGWR_SHADOW_EN
    ,
    .shadow_addr  (shadow_addr),
    .shadow_data  (shadow_data)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: logs every rising strobe and flags address/data changes
  // while the strobe is high
  logic       prev_strobe = 1'b0;
  logic [2:0] prev_addr   = '0;
  logic [4:0] prev_data   = '0;
  logic [2:0] mon_addr [256];
  logic [4:0] mon_data [256];
  int         mon_cyc  [256];
  int         mon_n       = 0;
  int         stable_viol = 0;

  always @(negedge clk) begin
    if (write_strobe && !prev_strobe && mon_n < 256) begin
      mon_addr[mon_n] = address;
      mon_data[mon_n] = data;
      mon_cyc[mon_n]  = cyc;
      mon_n = mon_n + 1;
    end
    if (write_strobe && prev_strobe && (address !== prev_addr || data !== prev_data))
      stable_viol = stable_viol + 1;
    prev_strobe = write_strobe;
    prev_addr   = address;
    prev_data   = data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [2:0] a, input logic [4:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      errors++;
      $display("FAIL push_timeout: cmd_ready=%0b required 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick();
    tick();
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_data = '0;
`ifdef SGWR_SHADOW_EN
    shadow_addr = '0;
`endif
    tick();
    tick();
    checks += 5;
    if (write_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %0b want 0", write_strobe); end
    if (address !== 3'd0)      begin errors++; $display("FAIL reset_addr: got %0d want 0", address); end
    if (data !== 5'd0)         begin errors++; $display("FAIL reset_data: got %0d want 0", data); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    if (cmd_ready !== 1'b1)    begin errors++; $display("FAIL reset_ready: got %0b want 1", cmd_ready); end
    rst = 1'b0;
    tick();
  endtask

  // Push at edge k; address/data at k+1, strobe high k+3..k+6, busy low at k+11
  task automatic test_single();
    logic exp_s;
    cmd_valid = 1'b1;
    cmd_addr  = 3'd2;
    cmd_data  = 5'd17;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks += 3;
    if (address !== 3'd2)      begin errors++; $display("FAIL single_addr: got %0d want 2", address); end
    if (data !== 5'd17)        begin errors++; $display("FAIL single_data: got %0d want 17", data); end
    if (write_strobe !== 1'b0) begin errors++; $display("FAIL single_setup_strobe: got %0b want 0", write_strobe); end
    for (int i = 2; i <= 11; i++) begin
      tick();
      exp_s = (i >= 1 + SETUP) && (i <= SETUP + STROBE);
      checks++;
      if (write_strobe !== exp_s) begin
        errors++;
        $display("FAIL single_strobe_k%0d: got %0b want %0b", i, write_strobe, exp_s);
      end
      if (i == 10) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_k10: got %0b want 1", busy); end
      end
      if (i == 11) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_k11: got %0b want 0", busy); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = mon_n;
    for (int i = 0; i < 5; i++) push_one(3'(i), 5'(i * 3 + 1));
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %0b want 0", cmd_ready); end
    push_one(3'd5, 5'd16);
    wait_idle();
    checks++;
    if (mon_n - base !== 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", mon_n - base); end
    for (int i = 0; i < 6 && base + i < mon_n; i++) begin
      checks++;
      if (mon_addr[base+i] !== 3'(i) || mon_data[base+i] !== 5'(i * 3 + 1)) begin
        errors++;
        $display("FAIL b2b_order_%0d: got %0d/%0d want %0d/%0d", i, mon_addr[base+i],
                 mon_data[base+i], i, i * 3 + 1);
      end
      if (i > 0) begin
        checks++;
        if (mon_cyc[base+i] - mon_cyc[base+i-1] !== PERIOD) begin
          errors++;
          $display("FAIL b2b_period_%0d: got %0d want %0d", i,
                   mon_cyc[base+i] - mon_cyc[base+i-1], PERIOD);
        end
      end
    end
  endtask

  // Valid held high with a fresh tag each cycle; pops while full must refuse
  task automatic test_full_pop();
    int         base;
    int         pwf;
    logic       rdy;
    logic [7:0] prev_ad;
    logic [4:0] exp_d [$];
    base = mon_n;
    pwf  = 0;
    prev_ad = {address, data};
    cmd_valid = 1'b1;
    for (int t = 0; t < 32; t++) begin
      cmd_addr = 3'(t);
      cmd_data = 5'(t);
      rdy = cmd_ready;
      if (rdy) exp_d.push_back(5'(t));
      tick();
      if ({address, data} !== prev_ad && !rdy) pwf++;
      prev_ad = {address, data};
    end
    cmd_valid = 1'b0;
    wait_idle();
    checks += 2;
    if (pwf == 0) begin errors++; $display("FAIL full_pop_seen: got %0d want >0", pwf); end
    if (mon_n - base !== exp_d.size()) begin
      errors++;
      $display("FAIL full_pop_count: got %0d want %0d", mon_n - base, exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && base + i < mon_n; i++) begin
      checks++;
      if (mon_data[base+i] !== exp_d[i] || mon_addr[base+i] !== exp_d[i][2:0]) begin
        errors++;
        $display("FAIL full_pop_item_%0d: got %0d want %0d", i, mon_data[base+i], exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int n;
    n = 0;
    push_one(3'd6, 5'd21);
    push_one(3'd1, 5'd2);
    push_one(3'd3, 5'd4);
    while (!write_strobe && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (write_strobe !== 1'b1) begin errors++; $display("FAIL rstmid_strobe_rise: got %0b want 1", write_strobe); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 5;
    if (write_strobe !== 1'b0) begin errors++; $display("FAIL rstmid_strobe: got %0b want 0", write_strobe); end
    if (address !== 3'd0)      begin errors++; $display("FAIL rstmid_addr: got %0d want 0", address); end
    if (data !== 5'd0)         begin errors++; $display("FAIL rstmid_data: got %0d want 0", data); end
    if (cmd_ready !== 1'b1)    begin errors++; $display("FAIL rstmid_ready: got %0b want 1", cmd_ready); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
    base = mon_n;
    repeat (20) tick();
    checks += 2;
    if (mon_n !== base) begin errors++; $display("FAIL rstmid_no_strobe: got %0d want 0", mon_n - base); end
    if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_empty: busy got %0b want 0", busy); end
  endtask

  task automatic test_stable();
    int         base;
    logic [2:0] ea [50];
    logic [4:0] ed [50];
    base = mon_n;
    for (int i = 0; i < 50; i++) begin
      ea[i] = 3'($urandom_range(0, 7));
      ed[i] = 5'($urandom_range(0, 31));
      push_one(ea[i], ed[i]);
    end
    wait_idle();
    checks += 2;
    if (mon_n - base !== 50) begin errors++; $display("FAIL stable_count: got %0d want 50", mon_n - base); end
    if (stable_viol !== 0)   begin errors++; $display("FAIL stable_hold: got %0d changes want 0", stable_viol); end
    for (int i = 0; i < 50 && base + i < mon_n; i++) begin
      checks++;
      if (mon_addr[base+i] !== ea[i] || mon_data[base+i] !== ed[i]) begin
        errors++;
        $display("FAIL stable_item_%0d: got %0d/%0d want %0d/%0d", i, mon_addr[base+i],
                 mon_data[base+i], ea[i], ed[i]);
      end
    end
  endtask

`ifdef SGWR_SHADOW_EN
  task automatic test_shadow();
    push_one(3'd5, 5'd9);
    wait_idle();
    shadow_addr = 3'd5;
    #1;
    checks++;
    if (shadow_data !== 5'd9) begin errors++; $display("FAIL shadow_first: got %0d want 9", shadow_data); end
    push_one(3'd5, 5'd30);
    wait_idle();
    #1;
    checks++;
    if (shadow_data !== 5'd30) begin errors++; $display("FAIL shadow_second: got %0d want 30", shadow_data); end
    shadow_addr = 3'd4;
    #1;
    checks++;
    if (shadow_data !== 5'd0) begin errors++; $display("FAIL shadow_addr4: got %0d want 0", shadow_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    repeat (3) tick();
    test_back_to_back();
    test_full_pop();
    test_reset_mid();
    test_stable();
`ifdef SGWR_SHADOW_EN
    test_reset();
    test_shadow();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
